// File: rtl/spram_dma.sv
// spram_dma: single-port RAM DMA engine performing FILL, COPY and SUM
// commands one at a time over a modulo-addressed RAM.
module spram_dma #(
  parameter int data_width = 8,
  parameter int addr_width = 10
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [addr_width-1:0]            cmd_src,
  input  logic [addr_width-1:0]            cmd_dst,
  input  logic [addr_width:0]              cmd_len,
  input  logic [data_width-1:0]            cmd_data,
  output logic                             busy,
  output logic                             done,
  output logic [data_width+addr_width-1:0] sum,
  output logic                             mem_cs,
  output logic                             mem_wren,
  output logic [addr_width-1:0]            mem_address,
  output logic [data_width-1:0]            mem_data,
  input  logic [data_width-1:0]            mem_q
);

  localparam int SW = data_width + addr_width;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_CP_RD    = 3'd2;
  localparam logic [2:0] S_CP_WR    = 3'd3;
  localparam logic [2:0] S_SUM_RD   = 3'd4;
  localparam logic [2:0] S_SUM_LAST = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_SUM  = 2'd2;

  logic [2:0]            state_q, state_d;
  logic [addr_width-1:0] src_q, src_d;
  logic [addr_width-1:0] dst_q, dst_d;
  logic [addr_width:0]   len_q, len_d;
  logic [data_width-1:0] fill_q, fill_d;
  logic [addr_width:0]   cnt_q, cnt_d;
  logic [SW-1:0]         acc_q, acc_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] wdata_q, wdata_d;

  logic [addr_width:0]   cnt_inc;
  logic                  last;
  logic [addr_width-1:0] src_addr;
  logic [addr_width-1:0] dst_addr;
  logic [SW-1:0]         acc_add;
  logic                  cs;
  logic                  wren;

  // Shared datapath terms: counter step, last-word test, wrapped addresses, accumulator add
  always_comb begin
    cnt_inc  = cnt_q + (addr_width+1)'(1);
    last     = (cnt_inc == len_q);
    src_addr = src_q + cnt_q[addr_width-1:0];
    dst_addr = dst_q + cnt_q[addr_width-1:0];
    acc_add  = acc_q + SW'(mem_q);
  end

  // Next-state, command latching and RAM port drive; address/data hold their last value when idle
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cs      = 1'b0;
    wren    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          len_d  = cmd_len;
          fill_d = cmd_data;
          cnt_d  = '0;
          acc_d  = '0;
          if (cmd_len == '0) begin
            state_d = S_FIN;
          end else begin
            case (cmd_op)
              OP_FILL: state_d = S_FILL;
              OP_COPY: state_d = S_CP_RD;
              OP_SUM:  state_d = S_SUM_RD;
              default: state_d = S_FIN;
            endcase
          end
        end
      end
      S_FILL: begin
        cs      = 1'b1;
        wren    = 1'b1;
        addr_d  = dst_addr;
        wdata_d = fill_q;
        if (last) state_d = S_FIN;
        else      cnt_d   = cnt_inc;
      end
      S_CP_RD: begin
        cs      = 1'b1;
        addr_d  = src_addr;
        state_d = S_CP_WR;
      end
      S_CP_WR: begin
        cs      = 1'b1;
        wren    = 1'b1;
        addr_d  = dst_addr;
        wdata_d = mem_q;
        if (last) begin
          state_d = S_FIN;
        end else begin
          cnt_d   = cnt_inc;
          state_d = S_CP_RD;
        end
      end
      S_SUM_RD: begin
        // Read i is issued while the word from read i-1 arrives on mem_q
        cs     = 1'b1;
        addr_d = src_addr;
        if (cnt_q != '0) acc_d = acc_add;
        if (last) state_d = S_SUM_LAST;
        else      cnt_d   = cnt_inc;
      end
      S_SUM_LAST: begin
        acc_d   = acc_add;
        sum_d   = acc_add;
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register update with asynchronous abort to IDLE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Status and RAM port outputs
  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_FIN);
    sum         = sum_q;
    mem_cs      = cs;
    mem_wren    = wren;
    mem_address = addr_d;
    mem_data    = wdata_d;
  end

endmodule
